// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and hands results to decode.
// Build option IFU_MISALIGN_CHK_EN: a misaligned redirect target raises a fetch fault instead of being truncated.
module ifu_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic [INST_WIDTH-1:0] instr_idu_o,
  output logic [ADDR_WIDTH-1:0] pc_idu_o,
  output logic                  valid_idu_o,
  input  logic                  ready_idu_i,
  input  logic                  redirect_en_exeu_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_exeu_i,
  output logic                  fetch_err_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  drop_q, drop_d;
  logic                  capture;
  logic [INST_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] pc_idu_q;
  logic                  redir_ok, redir_bad;
  logic [ADDR_WIDTH-1:0] target;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_bad = redirect_en_exeu_i && (redirect_pc_exeu_i[1:0] != 2'b00);
  assign redir_ok  = redirect_en_exeu_i && (redirect_pc_exeu_i[1:0] == 2'b00);
  assign target    = redirect_pc_exeu_i;
`else
  assign redir_bad = 1'b0;
  assign redir_ok  = redirect_en_exeu_i;
  assign target    = redirect_pc_exeu_i & ~ADDR_WIDTH'(3);
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every variable gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    capture = 1'b0;
    if (redir_bad) begin
      state_d = ERR;
      drop_d  = 1'b0;
    end else if (redir_ok) begin
      pc_d    = target;
      drop_d  = 1'b0;
      state_d = REQ;
      // An accepted or still-outstanding old fetch must have its response discarded.
      if ((state_q == REQ && imem_req_ready_i) || (state_q == WAIT && !imem_rsp_valid_i)) begin
        state_d = WAIT;
        drop_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (imem_req_ready_i) state_d = WAIT;
        WAIT: begin
          if (imem_rsp_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (imem_rsp_err_i) begin
              state_d = ERR;
            end else begin
              capture = 1'b1;
              pc_d    = pc_q + ADDR_WIDTH'(4);
              state_d = HOLD;
            end
          end
        end
        HOLD:    if (ready_idu_i) state_d = REQ;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      instr_q  <= '0;
      pc_idu_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      if (capture) begin
        instr_q  <= imem_rsp_data_i;
        pc_idu_q <= pc_q;
      end
    end
  end

  always_comb begin
    imem_req_valid_o = (state_q == REQ);
    imem_req_addr_o  = pc_q;
    valid_idu_o      = (state_q == HOLD);
    fetch_err_o      = (state_q == ERR);
    instr_idu_o      = instr_q;
    pc_idu_o         = pc_idu_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios, then random memory/decode/redirect traffic
// checked against a program-order PC model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic [31:0] instr_idu_o;
  logic [31:0] pc_idu_o;
  logic        valid_idu_o;
  logic        ready_idu_i;
  logic        redirect_en_exeu_i;
  logic [31:0] redirect_pc_exeu_i;
  logic        fetch_err_o;

  ifu_fetch dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid_o   (imem_req_valid_o),
    .imem_req_ready_i   (imem_req_ready_i),
    .imem_req_addr_o    (imem_req_addr_o),
    .imem_rsp_valid_i   (imem_rsp_valid_i),
    .imem_rsp_data_i    (imem_rsp_data_i),
    .imem_rsp_err_i     (imem_rsp_err_i),
    .instr_idu_o        (instr_idu_o),
    .pc_idu_o           (pc_idu_o),
    .valid_idu_o        (valid_idu_o),
    .ready_idu_i        (ready_idu_i),
    .redirect_en_exeu_i (redirect_en_exeu_i),
    .redirect_pc_exeu_i (redirect_pc_exeu_i),
    .fetch_err_o        (fetch_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory model state
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_lat;
  int          lat_min, lat_max;
  logic        rand_ready;
  logic        err_en;
  logic [31:0] err_addr;

  // Reference: next PC decode must receive, in program order
  logic [31:0] exp_pc;
  int          n_deliv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0050_0093;
    if (a == 32'h8000_0004) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_mem();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = $urandom;
    imem_rsp_err_i   = 1'($urandom_range(0, 1));
    imem_req_ready_i = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_lat == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_word(pend_addr);
        imem_rsp_err_i   = err_en && (pend_addr == err_addr);
        pend             = 1'b0;
      end else begin
        pend_lat--;
      end
    end else begin
      imem_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (imem_req_valid_o && imem_req_ready_i) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr_o;
        pend_lat  = $urandom_range(lat_min, lat_max);
      end
    end
  endtask

  // Architectural view: decode sees consecutive PCs, restarting at each redirect target.
  task automatic model();
    if (!rst_n) begin
      exp_pc = RESET_PC;
    end else if (redirect_en_exeu_i) begin
`ifdef IFU_MISALIGN_CHK_EN
      if (redirect_pc_exeu_i[1:0] == 2'b00) exp_pc = redirect_pc_exeu_i;
`else
      exp_pc = {redirect_pc_exeu_i[31:2], 2'b00};
`endif
    end else begin
      if (imem_req_valid_o && imem_req_ready_i) check("req_addr", imem_req_addr_o, exp_pc);
      if (valid_idu_o && ready_idu_i) begin
        check("deliv_pc", pc_idu_o, exp_pc);
        check("deliv_instr", instr_idu_o, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
    end
  endtask

  task automatic step();
    drive_mem();
    model();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_en_exeu_i = 1'b1;
    redirect_pc_exeu_i = tgt;
    step();
    redirect_en_exeu_i = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!imem_req_valid_o && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req_seen"}, 32'(imem_req_valid_o), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    ready_idu_i = 1'b0;
    redirect_en_exeu_i = 1'b0;
    redirect_pc_exeu_i = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = '0;
    imem_rsp_err_i = 1'b0;
    pend = 1'b0; pend_addr = '0; pend_lat = 0;
    lat_min = 0; lat_max = 0;
    rand_ready = 1'b0;
    err_en = 1'b0; err_addr = '0;
    exp_pc = RESET_PC; n_deliv = 0;

    @(negedge clk);
    repeat (3) step();
    check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("rst_req_addr", imem_req_addr_o, RESET_PC);
    check("rst_instr", instr_idu_o, 32'd0);
    check("rst_pc_idu", pc_idu_o, 32'd0);
    check("rst_valid_idu", 32'(valid_idu_o), 32'd0);
    check("rst_fetch_err", 32'(fetch_err_o), 32'd0);

    // First fetch after reset release
    rst_n = 1'b1;
    check("idle_no_req", 32'(imem_req_valid_o), 32'd0);
    step();
    check("first_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("first_req_addr", imem_req_addr_o, 32'h8000_0000);
    step();
    step();
    check("hold_valid", 32'(valid_idu_o), 32'd1);
    check("hold_pc", pc_idu_o, 32'h8000_0000);
    check("hold_instr", instr_idu_o, 32'h0050_0093);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(valid_idu_o), 32'd1);
      check("stall_no_req", 32'(imem_req_valid_o), 32'd0);
    end
    check("stall_pc", pc_idu_o, 32'h8000_0000);
    check("stall_instr", instr_idu_o, 32'h0050_0093);
    ready_idu_i = 1'b1;
    step();
    check("after_hs_valid", 32'(valid_idu_o), 32'd0);
    check("next_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("next_req_addr", imem_req_addr_o, 32'h8000_0004);

    // Redirect while waiting: late response must be dropped
    ready_idu_i = 1'b0;
    lat_min = 2; lat_max = 2;
    step();
    redirect(32'h8000_0100);
    lat_min = 0; lat_max = 0;
    wait_req("drop");
    check("drop_valid_idu", 32'(valid_idu_o), 32'd0);
    check("drop_req_addr", imem_req_addr_o, 32'h8000_0100);

    // Access fault, then recovery by redirect
    ready_idu_i = 1'b1;
    err_en = 1'b1; err_addr = 32'h8000_0100;
    step();
    step();
    check("err_flag", 32'(fetch_err_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("err_no_req", 32'(imem_req_valid_o), 32'd0);
      check("err_sticky", 32'(fetch_err_o), 32'd1);
      check("err_no_valid", 32'(valid_idu_o), 32'd0);
    end
    err_en = 1'b0;
    redirect(32'h8000_0000);
    check("err_cleared", 32'(fetch_err_o), 32'd0);
    check("err_recover_req", 32'(imem_req_valid_o), 32'd1);
    check("err_recover_addr", imem_req_addr_o, 32'h8000_0000);

    // PC wrap
    redirect(32'hFFFF_FFFC);
    wait_req("wrap_a");
    check("wrap_first_addr", imem_req_addr_o, 32'hFFFF_FFFC);
    step();
    wait_req("wrap_b");
    check("wrap_next_addr", imem_req_addr_o, 32'h0000_0000);

    // Reset in the middle of a fetch
    lat_min = 3; lat_max = 3;
    step();
    rst_n = 1'b0;
    step();
    check("midrst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("midrst_addr", imem_req_addr_o, RESET_PC);
    check("midrst_valid_idu", 32'(valid_idu_o), 32'd0);
    rst_n = 1'b1;
    lat_min = 0; lat_max = 0;
    wait_req("midrst");
    check("midrst_req_addr", imem_req_addr_o, RESET_PC);

    // Misaligned redirect target
    redirect(32'h8000_0102);
`ifdef IFU_MISALIGN_CHK_EN
    check("mis_err", 32'(fetch_err_o), 32'd1);
    step();
    check("mis_no_req", 32'(imem_req_valid_o), 32'd0);
    redirect(32'h8000_0200);
    check("mis_cleared", 32'(fetch_err_o), 32'd0);
    wait_req("mis");
    check("mis_recover_addr", imem_req_addr_o, 32'h8000_0200);
`else
    check("mis_no_err", 32'(fetch_err_o), 32'd0);
    wait_req("mis");
    check("mis_trunc_addr", imem_req_addr_o, 32'h8000_0100);
`endif

    // Random traffic against the program-order model
    rand_ready = 1'b1;
    lat_min = 0; lat_max = 3;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      ready_idu_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_en_exeu_i = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc_exeu_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
          1:       redirect_pc_exeu_i = $urandom;
          default: redirect_pc_exeu_i = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      step();
      redirect_en_exeu_i = 1'b0;
    end
    check("rand_progress", 32'(n_deliv > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
